parity_scheduler: RTL
=====================

Name: parity_scheduler

Overview:
- Shares one serial parity engine among NREQ requesters using round-robin arbitration.
- Accepts one WIDTH-bit word per grant and shifts it out MSB-first, one bit per cycle.
- Accumulates the word's parity and returns it with the requester ID over a valid/ready result port.
- Sits between multiple word producers and the serial link and parity consumer.

Parameters:
- NREQ, 4, number of requesters (>=2).
- WIDTH, 8, word width in bits (>=2).
- IDW, $clog2(NREQ), derived localparam (not overridable); width of the requester ID.

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester word valid.
- req_data  in  NREQ*WIDTH  requester i's word is slice [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot grant; transfer occurs when req_valid[i] & req_ready[i].
- serial_out  out  1  current serialized bit (MSB-first).
- serial_valid  out  1  high while serial_out carries a data bit.
- res_valid  out  1  parity result available.
- res_parity  out  1  XOR of all WIDTH bits (1 = odd number of ones).
- res_id  out  IDW  index of the requester that the result belongs to.
- res_ready  in  1  consumer accepts result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync-free deassert) values:
  - state=IDLE; rr_ptr=0; shift register and bit counter=0.
  - All outputs 0: req_ready, serial_out, serial_valid, res_valid, res_parity, res_id, busy.
  - Reset mid-operation abandons the word; no result is produced for it.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - req_ready is combinational: one-hot on the first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, … modulo NREQ.
  - All zeros if no request.
  - On a transfer edge: capture the word into the shift register; grant_id=i; bit counter=0; parity accumulator=0; go to SHIFT.
  - req_ready is 0 in every other state.
- SHIFT:
  - serial_valid=1; serial_out=shift_reg[WIDTH-1] (registered).
  - Each cycle: shift left by 1 with zero fill; parity ^= outgoing bit; counter++.
  - Always exactly WIDTH cycles, including all-zero words; no early exit on zero.
  - After the WIDTH-th bit, go to DONE.
- DONE:
  - res_valid=1; res_parity and res_id are stable until the handshake; serial_valid=0; serial_out=0.
  - On res_valid & res_ready: rr_ptr = grant_id+1 (wraps NREQ-1 -> 0); go to IDLE.
  - res_ready held low keeps DONE indefinitely (backpressure); no new grants are issued.
- Timing:
  - Transfer at edge T -> serial bits on cycles T+1..T+WIDTH -> res_valid from cycle T+WIDTH+1.
  - res_ready high on the first DONE cycle gives a 1-cycle DONE, then IDLE.
  - Minimum period per word is WIDTH+2 cycles (one IDLE cycle between words).
- Requester rules:
  - Requesters may drop req_valid before being granted without effect.
  - Requester data must be stable only in the transfer cycle.
- Simultaneous requests: only one grant per IDLE cycle; losers wait.
- Fairness: any continuously asserted request is served within NREQ grants.
- res_parity equals the reduction XOR of the captured word, independent of requester.

Decomposition:
- Shared package parity_pkg:
  - State encoding constants: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10; encoding 2'b11 recovers to IDLE.
  - Default WIDTH and NREQ constants.
- One sub-module, rr_arbiter: combinational round-robin one-hot grant from (req_valid, rr_ptr), plus encoded grant index.
- Shift, count and parity logic stays in parity_scheduler.

Test Plan:
- Single request: req 0 presents 8'b1011_0010 -> serial_out 1,0,1,1,0,0,1,0 on 8 consecutive cycles with serial_valid=1; then res_valid=1, res_parity=0, res_id=0.
- All-zero word: req 2 presents 8'h00 -> 8 zero bits with serial_valid high for all 8 cycles; res_parity=0, res_id=2; no early termination.
- Round robin: all four requesters held valid from reset, words 8'h01, 8'h03, 8'h07, 8'h0F -> grant order 0,1,2,3,0; res_parity sequence 1,0,1,0; 10-cycle spacing between grants.
- Backpressure: res_ready=0 for 20 cycles after res_valid -> res_valid, res_parity and res_id held; req_ready stays 0 throughout; on res_ready=1, IDLE next cycle and a new grant follows.
- Reset mid-shift: assert reset_n=0 at bit 4 of word 8'hFF -> all outputs 0 immediately (async); after release, req 0 wins first and no stale result appears.
- Drop-before-grant: req 1 pulses valid while req 0 is in SHIFT and deasserts before IDLE -> req 1 is never granted; only one result (id 0) is produced.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared constants for the parity scheduler block.
//   - FSM state encodings (2-bit; the unused 2'b11 code falls back to IDLE)
//   - default requester count and word width
package parity_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : per-requester request vector
//   ptr    : highest-priority requester index for this cycle
//   gnt    : one-hot grant (first set bit of req searching ptr, ptr+1, ... mod NREQ)
//   gnt_id : encoded index of the granted requester (0 when none)
//   any    : at least one request present
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            any
);

  always_comb begin
    int idx;
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      // rotate the search start to ptr; ptr < NREQ so one subtract wraps it
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parity_scheduler.sv
// Shares one serial parity engine among NREQ requesters.
// A round-robin grant captures one WIDTH-bit word, which is shifted out
// MSB-first (one bit per cycle) while its parity is accumulated; the parity
// and requester ID are then offered on a valid/ready result port.
// Ports:
//   clock, reset_n         : clock, async active-low reset
//   req_valid/req_data     : per-requester word offer (slice i*WIDTH +: WIDTH)
//   req_ready              : one-hot grant, only in IDLE
//   serial_out/serial_valid: serialized bit stream
//   res_valid/res_parity/res_id/res_ready : result handshake
//   busy                   : engine not idle
module parity_scheduler
  import parity_pkg::*;
#(
  parameter  int NREQ  = DEF_NREQ,
  parameter  int WIDTH = DEF_WIDTH,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    serial_out,
  output logic                    serial_valid,
  output logic                    res_valid,
  output logic                    res_parity,
  output logic [IDW-1:0]          res_id,
  input  logic                    res_ready,
  output logic                    busy
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_id;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    cnt;
  logic             parity;

  logic [NREQ-1:0]  arb_gnt;
  logic [IDW-1:0]   arb_id;
  logic             arb_any;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  logic idle, shifting, done;
  assign idle     = (state == ST_IDLE);
  assign shifting = (state == ST_SHIFT);
  assign done     = (state == ST_DONE);

  // Grant is combinational from req_valid; reset_n gating keeps it quiet
  // while reset is held even though the FSM already sits in IDLE.
  assign req_ready    = (idle && reset_n) ? arb_gnt : '0;
  assign serial_valid = shifting;
  assign serial_out   = shifting & shift_reg[WIDTH-1];
  assign res_valid    = done;
  assign res_parity   = done & parity;
  assign res_id       = done ? grant_id : '0;
  assign busy         = !idle;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      shift_reg <= '0;
      cnt       <= '0;
      parity    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            shift_reg <= req_data[int'(arb_id)*WIDTH +: WIDTH];
            grant_id  <= arb_id;
            cnt       <= '0;
            parity    <= 1'b0;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // fixed WIDTH-cycle run, no early exit on an all-zero remainder
          shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
          parity    <= parity ^ shift_reg[WIDTH-1];
          cnt       <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= ST_DONE;
        end
        ST_DONE: begin
          if (res_ready) begin
            rr_ptr <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
